// File: rtl/snn_pkg.sv
// Shared types, constants and helpers for the spike event path.
package snn_pkg;

  localparam int unsigned SNN_ADDR_WIDTH = 14;

  // Winner of the spike FIFO write port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EXT  = 2'd1,
    GNT_REC  = 2'd2
  } grant_t;

  // Increment a counter of the given width (<= 32), holding at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32) max_val = '1;
    else             max_val = (32'(1) << width) - 32'(1);
    if (val >= max_val) return max_val;
    return val + 32'(1);
  endfunction

endpackage

// File: rtl/spike_rec_buffer.sv
// Recurrent spike buffer: synchronous FIFO with flush; a push into a full
// buffer is accepted only when a pop frees a slot in the same cycle.
module spike_rec_buffer
  import snn_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = SNN_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [ADDR_WIDTH-1:0]      i_wdata,
  output logic [ADDR_WIDTH-1:0]      o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok) & ~i_flush;

  // Pointer and occupancy bookkeeping; flush empties the buffer at the edge.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/spike_event_arbiter.sv
// Round-robin arbiter sharing the spike FIFO write port between external
// events (zero-latency pass-through) and buffered recurrent spikes.
module spike_event_arbiter
  import snn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SNN_ADDR_WIDTH,
  parameter int unsigned REC_DEPTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rec_enable,
  input  logic                         i_flush,
  input  logic                         i_ext_valid,
  input  logic [ADDR_WIDTH-1:0]        i_ext_addr,
  output logic                         o_ext_ready,
  input  logic                         i_rec_valid,
  input  logic [ADDR_WIDTH-1:0]        i_rec_addr,
  input  logic                         i_fifo_full,
  output logic                         o_fifo_wr_en,
  output logic [ADDR_WIDTH-1:0]        o_fifo_wdata,
  output logic [$clog2(REC_DEPTH):0]   o_rec_count,
  output logic [CNT_WIDTH-1:0]         o_drop_count,
  output logic                         o_idle
);

  localparam int unsigned CW = $clog2(REC_DEPTH) + 1;

  grant_t                r_rr_last;
  grant_t                w_grant;
  logic [CNT_WIDTH-1:0]  r_drop_count;
  logic [ADDR_WIDTH-1:0] w_rec_head;
  logic [CW-1:0]         w_rec_count;
  logic                  w_rec_full;
  logic                  w_rec_empty;
  logic                  w_push_req;
  logic                  w_grant_ext;
  logic                  w_grant_rec;
  logic                  w_drop;

  assign w_push_req  = i_rec_valid & i_rec_enable & ~i_flush;
  assign w_grant_ext = (w_grant == GNT_EXT);
  assign w_grant_rec = (w_grant == GNT_REC);
  assign w_drop      = w_push_req & w_rec_full & ~w_grant_rec;

  spike_rec_buffer #(
    .DEPTH      (REC_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rec_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_pop   (w_grant_rec),
    .i_flush (i_flush),
    .i_wdata (i_rec_addr),
    .o_head  (w_rec_head),
    .o_count (w_rec_count),
    .o_full  (w_rec_full),
    .o_empty (w_rec_empty)
  );

  // Grant decision: single requester wins, ties go to whoever did not win last.
  always_comb begin
    w_grant = GNT_NONE;
    if (!rst && !i_fifo_full) begin
      if (i_ext_valid && !w_rec_empty)
        w_grant = (r_rr_last == GNT_EXT) ? GNT_REC : GNT_EXT;
      else if (i_ext_valid)
        w_grant = GNT_EXT;
      else if (!w_rec_empty)
        w_grant = GNT_REC;
    end
  end

  // Round-robin history; starts at REC so the first tie favours EXT.
  always_ff @(posedge clk) begin
    if (rst)                       r_rr_last <= GNT_REC;
    else if (w_grant != GNT_NONE)  r_rr_last <= w_grant;
  end

  // Saturating count of recurrent events lost to buffer overflow.
  always_ff @(posedge clk) begin
    if (rst)         r_drop_count <= '0;
    else if (w_drop) r_drop_count <= CNT_WIDTH'(sat_inc(32'(r_drop_count), CNT_WIDTH));
  end

  // Write-port mux driven straight from the grant.
  always_comb begin
    o_fifo_wdata = '0;
    if (w_grant_ext)      o_fifo_wdata = i_ext_addr;
    else if (w_grant_rec) o_fifo_wdata = w_rec_head;
  end

  assign o_ext_ready  = w_grant_ext;
  assign o_fifo_wr_en = w_grant_ext | w_grant_rec;
  assign o_rec_count  = w_rec_count;
  assign o_drop_count = r_drop_count;
  assign o_idle       = w_rec_empty & ~i_ext_valid;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Directed bench for spike_event_arbiter with hand-computed expectations.
module tb_spike_event_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned RD = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rec_enable;
  logic          flush;
  logic          ext_valid;
  logic [AW-1:0] ext_addr;
  logic          ext_ready;
  logic          rec_valid;
  logic [AW-1:0] rec_addr;
  logic          fifo_full;
  logic          wr_en;
  logic [AW-1:0] wdata;
  logic [4:0]    rec_count;
  logic [CW-1:0] drop_count;
  logic          idle;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spike_event_arbiter #(
    .ADDR_WIDTH (AW),
    .REC_DEPTH  (RD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rec_enable (rec_enable),
    .i_flush      (flush),
    .i_ext_valid  (ext_valid),
    .i_ext_addr   (ext_addr),
    .o_ext_ready  (ext_ready),
    .i_rec_valid  (rec_valid),
    .i_rec_addr   (rec_addr),
    .i_fifo_full  (fifo_full),
    .o_fifo_wr_en (wr_en),
    .o_fifo_wdata (wdata),
    .o_rec_count  (rec_count),
    .o_drop_count (drop_count),
    .o_idle       (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic ev, input int ea, input logic rv,
                       input int ra, input logic full, input logic fl);
    @(negedge clk);
    rst       = r;
    ext_valid = ev;
    ext_addr  = AW'(ea);
    rec_valid = rv;
    rec_addr  = AW'(ra);
    fifo_full = full;
    flush     = fl;
    #1;
  endtask

  initial begin
    rst = 1'b1; rec_enable = 1'b1; flush = 1'b0; ext_valid = 1'b0; ext_addr = '0;
    rec_valid = 1'b0; rec_addr = '0; fifo_full = 1'b0;

    // Reset: outputs forced low even with an external request present.
    drive(1, 1, 33, 0, 0, 0, 0);
    drive(1, 1, 33, 0, 0, 0, 0);
    chk("rst_ready", 32'(ext_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wdata", 32'(wdata), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(rec_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_idle", 32'(idle), 1);

    // 1: external-only pass-through.
    for (int i = 5; i <= 7; i++) begin
      drive(0, 1, i, 0, 0, 0, 0);
      chk("ext_ready", 32'(ext_ready), 1);
      chk("ext_wr_en", 32'(wr_en), 1);
      chk("ext_wdata", 32'(wdata), 32'(i));
    end

    // 2: alternating service, first tie to EXT after reset.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 9, 1, 100, 0, 0);
    chk("alt0_wdata", 32'(wdata), 9);
    chk("alt0_ready", 32'(ext_ready), 1);
    drive(0, 1, 9, 1, 101, 0, 0);
    chk("alt1_wdata", 32'(wdata), 100);
    chk("alt1_ready", 32'(ext_ready), 0);
    drive(0, 1, 9, 0, 0, 0, 0);
    chk("alt2_wdata", 32'(wdata), 9);
    chk("alt2_count", 32'(rec_count), 1);
    drive(0, 1, 9, 0, 0, 0, 0);
    chk("alt3_wdata", 32'(wdata), 101);
    chk("alt3_wr_en", 32'(wr_en), 1);

    // 3: backpressure from FIFO full; ext wins one, rec buffered, then stall.
    drive(0, 1, 9, 1, 200, 0, 0);
    chk("bp_pre_wdata", 32'(wdata), 9);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 9, 0, 0, 1, 0);
      chk("bp_wr_en", 32'(wr_en), 0);
      chk("bp_ready", 32'(ext_ready), 0);
      chk("bp_count", 32'(rec_count), 1);
    end
    drive(0, 1, 9, 0, 0, 0, 0);
    chk("bp_res_wdata", 32'(wdata), 200);
    chk("bp_res_ready", 32'(ext_ready), 0);
    drive(0, 1, 9, 0, 0, 0, 0);
    chk("bp_res2_wdata", 32'(wdata), 9);
    chk("bp_res2_count", 32'(rec_count), 0);

    // 4: overflow with FIFO full, then ordered drain.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) drive(0, 0, 0, 1, 300 + i, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("ovf_count", 32'(rec_count), 16);
    chk("ovf_drop", 32'(drop_count), 2);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drain_wr_en", 32'(wr_en), 1);
      chk("drain_wdata", 32'(wdata), 32'(300 + i));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("drain_count", 32'(rec_count), 0);
    chk("drain_drop", 32'(drop_count), 2);
    chk("drain_wr_en_end", 32'(wr_en), 0);

    // 5: full buffer push+pop same cycle, then flush with 5 entries.
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 400 + i, 1, 0);
    drive(0, 0, 0, 1, 500, 0, 0);
    chk("pp_count_pre", 32'(rec_count), 16);
    chk("pp_wdata", 32'(wdata), 400);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("pp_count", 32'(rec_count), 16);
    chk("pp_drop", 32'(drop_count), 2);
    for (int i = 1; i <= 11; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("pp_drain_wdata", 32'(wdata), 32'(400 + i));
    end
    drive(0, 0, 0, 1, 999, 0, 1);
    chk("fl_count_pre", 32'(rec_count), 5);
    chk("fl_wr_en", 32'(wr_en), 1);
    chk("fl_wdata", 32'(wdata), 412);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl_count", 32'(rec_count), 0);
    chk("fl_drop", 32'(drop_count), 2);
    chk("fl_wr_en_after", 32'(wr_en), 0);
    chk("fl_idle", 32'(idle), 1);

    // 6: reset mid-burst discards buffered events without counting drops.
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 600 + i, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("mr_count_pre", 32'(rec_count), 7);
    drive(1, 1, 3, 0, 0, 0, 0);
    chk("mr_ready", 32'(ext_ready), 0);
    chk("mr_wr_en", 32'(wr_en), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("mr_count", 32'(rec_count), 0);
    chk("mr_drop", 32'(drop_count), 0);
    chk("mr_wr_en_after", 32'(wr_en), 0);
    chk("mr_idle", 32'(idle), 1);
    drive(0, 1, 4, 0, 0, 0, 0);
    chk("mr_idle_ext", 32'(idle), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
